// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction width and the bubble instruction value.
//
// Build option:
//   FETCH_BOUNDS_CHECK_EN - when defined, fetch addresses beyond the last
//                           word of instruction memory park the unit in FAULT.
//                           When undefined the pc simply wraps.
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK_EN = 1'b1;
`else
    localparam bit BOUNDS_CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// ----------------------------------------------------------------------------
// fetch_pc_gen
// Purely combinational next-pc selection for fetch_unit: increment, branch
// redirect, hold, and (with FETCH_BOUNDS_CHECK_EN) range check of the
// candidate address. Holds no state.
//
// Ports:
//   state_i          current fetch FSM state
//   pc_i             current pc register
//   stall_i          downstream not ready
//   branch_taken_i   redirect request
//   branch_target_i  redirect byte address (low two bits ignored)
//   pc_d_o           next value for the pc register
//   addr_bad_o       the requested pc update was out of range and rejected
// ----------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MEM_BYTES = 64
) (
    input  fetch_state_e      state_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_d_o,
    output logic              addr_bad_o
);

    // Highest legal word address, one bit wider so an increment that carries
    // out of ADDR_W is still seen as out of range.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(MEM_BYTES - 4);

    logic [ADDR_W-1:0] target_al;
    logic [ADDR_W:0]   inc_full;
    logic              target_bad;
    logic              inc_bad;

    assign target_al  = branch_target_i & ~ADDR_W'(3);
    assign inc_full   = {1'b0, pc_i} + (ADDR_W+1)'(4);
    assign target_bad = BOUNDS_CHECK_EN && ({1'b0, target_al} > LAST_WORD);
    assign inc_bad    = BOUNDS_CHECK_EN && (inc_full > LAST_WORD);

    always_comb begin
        pc_d_o     = pc_i;
        addr_bad_o = 1'b0;
        case (state_i)
            FETCH: begin
                // Branch wins over stall.
                if (branch_taken_i) begin
                    addr_bad_o = target_bad;
                    if (!target_bad) pc_d_o = target_al;
                end else if (!stall_i) begin
                    addr_bad_o = inc_bad;
                    // Dropping the carry bit gives the modulo-2^ADDR_W wrap.
                    if (!inc_bad) pc_d_o = inc_full[ADDR_W-1:0];
                end
            end
            FAULT: begin
                if (branch_taken_i) begin
                    addr_bad_o = target_bad;
                    if (!target_bad) pc_d_o = target_al;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Single-issue instruction fetch stage. Presents the pc to a combinational
// instruction memory and registers the returned word toward decode, one
// instruction per cycle, with stall hold and branch redirect.
//
// Build option:
//   FETCH_BOUNDS_CHECK_EN - enables out-of-range detection (FAULT state and
//                           fetch_fault). Undefined: fetch_fault is constant 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem_addr      byte address to instruction memory (= pc register)
//   imem_instr     instruction word returned in the same cycle
//   stall          downstream not ready; hold all state
//   branch_taken   redirect request (beats stall)
//   branch_target  redirect byte address, low two bits forced to 0
//   if_instr       registered instruction to decode
//   if_pc          address of if_instr
//   if_valid       if_instr/if_pc are meaningful
//   fetch_fault    out-of-range fetch detected
// ----------------------------------------------------------------------------
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | single cycle after reset release, nothing fetched yet
//   FETCH | normal operation, capture imem_instr when not stalled
//   FAULT | pc update was out of range; wait for in-range branch or reset
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MEM_BYTES = 64,
    parameter int RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               fetch_fault
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               addr_bad;
    logic [INSTR_W-1:0] if_instr_q;
    logic [ADDR_W-1:0]  if_pc_q;
    logic               if_valid_q;
    logic               fault_q;

    fetch_pc_gen #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_gen (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_d_o          (pc_d),
        .addr_bad_o      (addr_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            // pc_gen already folds hold/increment/redirect/reject into pc_d.
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        if_valid_q <= 1'b0;
                        if (addr_bad) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_instr_q <= imem_instr;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        // The last in-range word is still delivered; the
                        // fault flag follows on the next edge.
                        if (addr_bad) state_q <= FAULT;
                    end
                end
                FAULT: begin
                    if (branch_taken && !addr_bad) begin
                        state_q    <= FETCH;
                        fault_q    <= 1'b0;
                        if_valid_q <= 1'b0;
                    end else begin
                        fault_q <= 1'b1;
                        if (branch_taken || !stall) if_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign fetch_fault = fault_q & BOUNDS_CHECK_EN;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_instr;
    logic [5:0]  if_pc;
    logic        if_valid;
    logic        fetch_fault;

    logic [31:0] mem [16];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_pc;
    int          m_if_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_idle;

    fetch_unit #(.ADDR_W(6), .MEM_BYTES(64), .RESET_PC(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .fetch_fault   (fetch_fault)
    );

    assign imem_instr = mem[imem_addr[5:2]];

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 0;
        m_if_pc = 0;
        m_instr = 32'h0;
        m_valid = 0;
        m_idle  = 1;
    endtask

    // Advance one rising edge; the model consumes the inputs present at it.
    task automatic tick();
        @(posedge clk);
        if (m_idle) begin
            m_idle = 0;
        end else if (branch_taken) begin
            m_pc    = int'(branch_target) - (int'(branch_target) % 4);
            m_valid = 0;
        end else if (!stall) begin
            m_instr = mem[m_pc / 4];
            m_if_pc = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 4) % 64;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        model_reset();
        #2;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 6'd0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b pc=%0h instr=%0h exp 0/0/0", if_valid, if_pc, if_instr);
        end
        checks++;
        if (imem_addr !== 6'd0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr got addr=%0h fault=%0b exp 0/0", imem_addr, fetch_fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 6'd0) begin
            failures++;
            $display("FAIL idle_cycle got valid=%0b addr=%0h exp 0/0", if_valid, imem_addr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 6'd0 || if_instr !== 32'hEA000005) begin
            failures++;
            $display("FAIL first_fetch got valid=%0b pc=%0h instr=%0h exp 1/0/EA000005", if_valid, if_pc, if_instr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 6'd4 || if_instr !== 32'hE2901035) begin
            failures++;
            $display("FAIL second_fetch got valid=%0b pc=%0h instr=%0h exp 1/4/E2901035", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_stall();
        tick();
        checks++;
        if (if_pc !== 6'd8 || imem_addr !== 6'd12) begin
            failures++;
            $display("FAIL stall_setup got pc=%0h addr=%0h exp 8/c", if_pc, imem_addr);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_pc !== 6'd8 || if_instr !== mem[2] || if_valid !== 1'b1 || imem_addr !== 6'd12) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got pc=%0h instr=%0h valid=%0b addr=%0h exp 8/%0h/1/c",
                         i, if_pc, if_instr, if_valid, imem_addr, mem[2]);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_pc !== 6'd12 || if_instr !== mem[3] || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume got pc=%0h instr=%0h valid=%0b exp c/%0h/1", if_pc, if_instr, if_valid, mem[3]);
        end
    endtask

    task automatic test_branch_stall();
        branch_taken = 1'b1;
        branch_target = 6'h17;
        stall = 1'b1;
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 6'h14) begin
            failures++;
            $display("FAIL branch_redirect got valid=%0b addr=%0h exp 0/14", if_valid, imem_addr);
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 6'h14 || if_instr !== 32'hE3A05000) begin
            failures++;
            $display("FAIL branch_target_fetch got valid=%0b pc=%0h instr=%0h exp 1/14/E3A05000", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_wrap();
        bit reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (m_valid && m_if_pc == 60) reached = 1;
        end
        checks++;
        if (!reached || if_pc !== 6'd60 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_at_60 got pc=%0h valid=%0b reached=%0b exp 3c/1/1", if_pc, if_valid, reached);
        end
        tick();
        checks++;
        if (if_pc !== 6'd0 || if_valid !== 1'b1 || if_instr !== mem[0] || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL wrap_to_0 got pc=%0h valid=%0b instr=%0h fault=%0b exp 0/1/%0h/0",
                     if_pc, if_valid, if_instr, fetch_fault, mem[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 6'($urandom_range(0, 63));
            tick();
            checks++;
            if (imem_addr !== 6'(m_pc) || if_valid !== m_valid || fetch_fault !== 1'b0 ||
                (m_valid && (if_pc !== 6'(m_if_pc) || if_instr !== m_instr))) begin
                failures++;
                $display("FAIL random cyc=%0d got addr=%0h valid=%0b pc=%0h instr=%0h fault=%0b exp addr=%0h valid=%0b pc=%0h instr=%0h fault=0",
                         i, imem_addr, if_valid, if_pc, if_instr, fetch_fault, 6'(m_pc), m_valid, 6'(m_if_pc), m_instr);
            end
        end
        stall = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_fault();
        // Redirect near the top of memory, then run off the end.
        branch_taken = 1'b1;
        branch_target = 6'd52;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (if_pc !== 6'd60 || if_valid !== 1'b1 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_last_word got pc=%0h valid=%0b fault=%0b exp 3c/1/0", if_pc, if_valid, fetch_fault);
        end
        @(posedge clk); #1;
        checks++;
        if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 6'd60) begin
            failures++;
            $display("FAIL fault_enter got fault=%0b valid=%0b addr=%0h exp 1/0/3c", fetch_fault, if_valid, imem_addr);
        end
        branch_taken = 1'b1;
        branch_target = 6'h04;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        checks++;
        if (fetch_fault !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_exit got fault=%0b valid=%0b exp 0/0", fetch_fault, if_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (if_pc !== 6'd4 || if_valid !== 1'b1 || if_instr !== 32'hE2901035) begin
            failures++;
            $display("FAIL fault_refetch got pc=%0h valid=%0b instr=%0h exp 4/1/E2901035", if_pc, if_valid, if_instr);
        end
        m_pc    = 8;
        m_if_pc = 4;
        m_instr = mem[1];
        m_valid = 1;
    endtask

    task automatic test_reset_midstall();
        bit reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (m_valid && m_if_pc == 32) reached = 1;
        end
        checks++;
        if (!reached || if_pc !== 6'h20) begin
            failures++;
            $display("FAIL midstall_setup got pc=%0h reached=%0b exp 20/1", if_pc, reached);
        end
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 6'd0 || if_instr !== 32'h0 || imem_addr !== 6'd0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL midstall_reset got valid=%0b pc=%0h instr=%0h addr=%0h fault=%0b exp all 0",
                     if_valid, if_pc, if_instr, imem_addr, fetch_fault);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 6'd0) begin
            failures++;
            $display("FAIL restart_idle got valid=%0b addr=%0h exp 0/0", if_valid, imem_addr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 6'd0 || if_instr !== 32'hEA000005) begin
            failures++;
            $display("FAIL restart_fetch got valid=%0b pc=%0h instr=%0h exp 1/0/EA000005", if_valid, if_pc, if_instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'hEA000005;
        mem[1] = 32'hE2901035;
        mem[5] = 32'hE3A05000;

        test_reset();
        test_startup();
        test_stall();
        test_branch_stall();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_fault();
`else
        test_wrap();
        test_random();
`endif
        test_reset_midstall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning byte-address width of the instruction memory port.
REQ-002 SHALL have parameter MEM_BYTES, default 64, meaning instruction memory size in bytes.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the byte address fetched first after reset.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_addr, output, ADDR_W, byte address to the combinational instruction memory.
REQ-008 SHALL have port imem_instr, input, 32, instruction word returned in the same cycle.
REQ-009 SHALL have port stall, input, 1, downstream not ready; hold all state.
REQ-010 SHALL have port branch_taken, input, 1, redirect request from execute.
REQ-011 SHALL have port branch_target, input, ADDR_W, redirect byte address.
REQ-012 SHALL have port if_instr, output, 32, registered instruction to decode.
REQ-013 SHALL have port if_pc, output, ADDR_W, address of if_instr.
REQ-014 SHALL have port if_valid, output, 1, if_instr/if_pc are meaningful.
REQ-015 SHALL have port fetch_fault, output, 1, out-of-range fetch; tied 0 when FETCH_BOUNDS_CHECK_EN is undefined.

Function
REQ-016 SHALL drive imem_addr combinationally from the internal pc register.
REQ-017 SHALL implement states IDLE, FETCH and FAULT; IDLE lasts exactly one cycle after reset release and then moves to FETCH with if_valid still 0.
REQ-018 In FETCH with stall=0 and branch_taken=0, SHALL capture if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-019 With stall=1 and branch_taken=0, SHALL hold pc, if_instr, if_pc and if_valid unchanged.
REQ-020 With branch_taken=1, SHALL set pc<=branch_target with bits[1:0] forced to 0 and if_valid<=0 next cycle, regardless of stall (branch beats stall).
REQ-021 A transfer to decode SHALL occur on each rising edge where if_valid=1 and stall=0.
REQ-022 pc+4 SHALL be computed modulo 2^ADDR_W; 60+4 wraps to 0 at default width.
REQ-023 Steady-state throughput SHALL be one instruction per cycle; latency from pc to if_instr SHALL be one cycle.

Reset
REQ-024 On rst_n=0, SHALL asynchronously set pc=RESET_PC, state=IDLE, if_instr=0, if_pc=0, if_valid=0, fetch_fault=0.
REQ-025 Reset asserted mid-operation, including during stall, branch or FAULT, SHALL discard all in-flight state.

Configuration
REQ-026 Macro FETCH_BOUNDS_CHECK_EN: when defined, any pc update yielding an address > MEM_BYTES-4 SHALL enter FAULT with fetch_fault=1, if_valid=0 and pc held.
REQ-027 FETCH_BOUNDS_CHECK_EN defined: FAULT SHALL exit only on branch_taken with an in-range target, returning to FETCH and clearing fetch_fault, or on reset.
REQ-028 FETCH_BOUNDS_CHECK_EN undefined: FAULT SHALL be unreachable, pc SHALL wrap per REQ-022, and fetch_fault SHALL be constant 0.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, INSTR_W=32 and the NOP_INSTR=32'h0 constant.
REQ-030 Next-pc selection (increment, redirect, hold, bounds check) SHALL be a sub-module fetch_pc_gen; all registers SHALL live in fetch_unit.

Verification
REQ-031 Release reset with memory preloaded (0x00=32'hEA000005, 0x04=32'hE2901035) -> IDLE one cycle, then if_pc=0/if_instr=EA000005, next cycle if_pc=4/if_instr=E2901035, if_valid=1.
REQ-032 Assert stall for 3 cycles while if_pc=8 -> if_pc=8, if_instr and if_valid unchanged; imem_addr stays 12; fetch resumes at 12 on release.
REQ-033 branch_taken=1, target=0x17, together with stall=1 -> next cycle if_valid=0, imem_addr=0x14; following cycle if_pc=0x14, if_instr=E3A05000.
REQ-034 Macro undefined, run to pc=60 -> if_pc=60, then if_pc=0, valid continuous, fetch_fault=0.
REQ-035 Macro defined, run to pc=60 -> after if_pc=60 fetch_fault=1, if_valid=0; branch to 0x04 -> fetch_fault=0, if_pc=4 two cycles later.
REQ-036 Pulse rst_n low mid-stall at if_pc=0x20 -> outputs zero immediately, restart from RESET_PC via IDLE.
